// File: rtl/spell_pkg.sv
// Shared types for the spell data-stack engine: sequencer states and
// debug target select codes.
package spell_pkg;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_FAULT = 2'd2
   } state_e;

   localparam logic [1:0] DBG_SEL_CNT   = 2'd0;
   localparam logic [1:0] DBG_SEL_TOP   = 2'd1;
   localparam logic [1:0] DBG_SEL_BELOW = 2'd2;
   localparam logic [1:0] DBG_SEL_PUSH  = 2'd3;

endpackage

// File: rtl/spell_stack_unit_if.sv
// Execute-unit stack op channel. An op transfers on a cycle where
// op_valid && op_ready; the request fields must be stable while op_valid is high.
interface spell_stack_unit_if #(
   parameter int WIDTH = 8
);
   logic             op_valid;
   logic             op_ready;
   logic [1:0]       op_pop;
   logic [1:0]       op_push;
   logic [WIDTH-1:0] op_top;
   logic [WIDTH-1:0] op_below;

   modport master (
      output op_valid, op_pop, op_push, op_top, op_below,
      input  op_ready
   );

   modport slave (
      input  op_valid, op_pop, op_push, op_top, op_below,
      output op_ready
   );
endinterface

// File: rtl/spell_stack_ram.sv
// DEPTH x WIDTH register array, two async read ports and two write ports.
// Write port 0 wins on an address clash.
module spell_stack_ram #(
   parameter int  WIDTH = 8,
   parameter int  DEPTH = 32,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we0_i,
   input  logic [AW-1:0]    wa0_i,
   input  logic [WIDTH-1:0] wd0_i,
   input  logic             we1_i,
   input  logic [AW-1:0]    wa1_i,
   input  logic [WIDTH-1:0] wd1_i,
   input  logic [AW-1:0]    ra0_i,
   input  logic [AW-1:0]    ra1_i,
   output logic [WIDTH-1:0] rd0_o,
   output logic [WIDTH-1:0] rd1_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we1_i) mem_q[wa1_i] <= wd1_i;
      if (we0_i) mem_q[wa0_i] <= wd0_i;
   end

   assign rd0_o = mem_q[ra0_i];
   assign rd1_o = mem_q[ra1_i];
endmodule

// File: rtl/spell_stack_unit.sv
// Parametrised data stack with wrap/trap pointer policy, auto-clear sequencer
// and a serial debug load/dump shift register.
module spell_stack_unit
   import spell_pkg::*;
#(
   parameter int  WIDTH     = 8,
   parameter int  DEPTH     = 32,
   parameter int  WRAP_MODE = 1,
   localparam int SPW       = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   spell_stack_unit_if.slave op_if,
   output logic [WIDTH-1:0]  top,
   output logic [WIDTH-1:0]  below,
   output logic [SPW:0]      cnt,
   input  logic              clear,
   output logic              clear_busy,
   output logic              err_overflow,
   output logic              err_underflow,
   input  logic              err_clear,
   input  logic [1:0]        dbg_sel,
   input  logic              dbg_load,
   input  logic              dbg_dump,
   input  logic              dbg_shift_in,
   output logic              dbg_shift_out,
   output state_e            state_o
);
   localparam logic [SPW+2:0] DEPTH_X  = (SPW+3)'(DEPTH);
   localparam logic [SPW:0]   CNT_FULL = (SPW+1)'(DEPTH);
   localparam logic [SPW-1:0] IDX_LAST = SPW'(DEPTH-1);

   state_e           state_q;
   logic [SPW-1:0]   idx_q;
   logic [SPW:0]     cnt_q;
   logic             ovf_q;
   logic             unf_q;
   logic [WIDTH-1:0] shreg_q;
   logic             sout_q;

   logic             in_idle;
   logic             load_go;
   logic             op_go;
   logic             stack_go;
   logic [1:0]       eff_pop;
   logic [1:0]       eff_push;
   logic [WIDTH-1:0] eff_top;
   logic [SPW+2:0]   n_full;
   logic [SPW-1:0]   n_idx;
   logic [SPW-1:0]   top_idx;
   logic [SPW-1:0]   below_idx;
   logic [SPW:0]     n_cnt;
   logic [SPW:0]     cnt_load;
   logic [31:0]      sh_ext;
   logic             unf_hit;
   logic             ovf_hit;
   logic             fault_hit;
   logic [WIDTH-1:0] dump_val;
   logic             we0;
   logic             we1;
   logic [SPW-1:0]   wa0;
   logic [SPW-1:0]   wa1;
   logic [WIDTH-1:0] wd0;
   logic [WIDTH-1:0] wd1;

   assign in_idle        = (state_q == ST_IDLE);
   assign load_go        = in_idle && !clear && dbg_load;
   assign op_if.op_ready = in_idle && !clear && !dbg_load;
   assign op_go          = op_if.op_valid && op_if.op_ready;
   assign stack_go       = op_go || (load_go && dbg_sel == DBG_SEL_PUSH);

   // A debug PUSH load reuses the op datapath as push=1, pop=0.
   always_comb begin
      eff_pop  = (op_if.op_pop  == 2'd3) ? 2'd2 : op_if.op_pop;
      eff_push = (op_if.op_push == 2'd3) ? 2'd2 : op_if.op_push;
      eff_top  = op_if.op_top;
      if (load_go) begin
         eff_pop  = 2'd0;
         eff_push = 2'd1;
         eff_top  = shreg_q;
      end
   end

   assign n_full    = {2'b00, cnt_q} - (SPW+3)'(eff_pop) + (SPW+3)'(eff_push);
   assign n_idx     = n_full[SPW-1:0];
   assign unf_hit   = (SPW+1)'(eff_pop) > cnt_q;
   assign ovf_hit   = !unf_hit && (n_full > DEPTH_X);
   assign fault_hit = (WRAP_MODE == 0) && (unf_hit || ovf_hit);
   assign n_cnt     = (WRAP_MODE != 0) ? {1'b0, n_idx} : n_full[SPW:0];

   assign top_idx   = cnt_q[SPW-1:0] - SPW'(1);
   assign below_idx = cnt_q[SPW-1:0] - SPW'(2);

   assign sh_ext   = 32'(shreg_q);
   assign cnt_load = (WRAP_MODE != 0)       ? {1'b0, sh_ext[SPW-1:0]} :
                     (sh_ext > 32'(DEPTH))  ? CNT_FULL : sh_ext[SPW:0];

   // The PUSH select has no stored value of its own; a dump of it captures top.
   always_comb begin
      case (dbg_sel)
         DBG_SEL_CNT:   dump_val = WIDTH'(cnt_q);
         DBG_SEL_BELOW: dump_val = below;
         default:       dump_val = top;
      endcase
   end

   always_comb begin
      we0 = 1'b0;
      wa0 = '0;
      wd0 = '0;
      we1 = 1'b0;
      wa1 = '0;
      wd1 = '0;
      if (state_q == ST_CLEAR) begin
         we0 = 1'b1;
         wa0 = idx_q;
      end else if (stack_go && !fault_hit) begin
         we0 = (eff_push != 2'd0);
         wa0 = n_idx - SPW'(1);
         wd0 = eff_top;
         we1 = (eff_push == 2'd2);
         wa1 = n_idx - SPW'(2);
         wd1 = op_if.op_below;
      end else if (load_go && dbg_sel == DBG_SEL_TOP) begin
         we0 = 1'b1;
         wa0 = top_idx;
         wd0 = shreg_q;
      end else if (load_go && dbg_sel == DBG_SEL_BELOW) begin
         we0 = 1'b1;
         wa0 = below_idx;
         wd0 = shreg_q;
      end
   end

   spell_stack_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we0_i (we0),
      .wa0_i (wa0),
      .wd0_i (wd0),
      .we1_i (we1),
      .wa1_i (wa1),
      .wd1_i (wd1),
      .ra0_i (top_idx),
      .ra1_i (below_idx),
      .rd0_o (top),
      .rd1_o (below)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_CLEAR;
         idx_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         shreg_q <= '0;
         sout_q  <= 1'b0;
      end else begin
         sout_q  <= shreg_q[WIDTH-1];
         shreg_q <= dbg_dump ? dump_val : {shreg_q[WIDTH-2:0], dbg_shift_in};
         case (state_q)
            ST_CLEAR: begin
               idx_q <= idx_q + SPW'(1);
               if (idx_q == IDX_LAST) state_q <= ST_IDLE;
            end
            ST_IDLE: begin
               if (clear) begin
                  cnt_q   <= '0;
                  idx_q   <= '0;
                  ovf_q   <= 1'b0;
                  unf_q   <= 1'b0;
                  state_q <= ST_CLEAR;
               end else begin
                  if (err_clear) begin
                     ovf_q <= 1'b0;
                     unf_q <= 1'b0;
                  end
                  if (stack_go) begin
                     if (fault_hit) begin
                        ovf_q   <= ovf_hit;
                        unf_q   <= unf_hit;
                        state_q <= ST_FAULT;
                     end else begin
                        cnt_q <= n_cnt;
                     end
                  end else if (load_go && dbg_sel == DBG_SEL_CNT) begin
                     cnt_q <= cnt_load;
                  end
               end
            end
            ST_FAULT: begin
               if (clear) begin
                  cnt_q   <= '0;
                  idx_q   <= '0;
                  ovf_q   <= 1'b0;
                  unf_q   <= 1'b0;
                  state_q <= ST_CLEAR;
               end else if (err_clear) begin
                  ovf_q   <= 1'b0;
                  unf_q   <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_CLEAR;
         endcase
      end
   end

   assign cnt           = cnt_q;
   assign clear_busy    = (state_q == ST_CLEAR);
   assign err_overflow  = ovf_q;
   assign err_underflow = unf_q;
   assign dbg_shift_out = sout_q;
   assign state_o       = state_q;
endmodule
